// File: rtl/scan_shift_ctrl_if.sv
// ---------------------------------------------------------------------------
// scan_shift_ctrl_if
// Pattern-in / response-out handshake bundle of the scan shift controller.
//   pat_data  [CHAIN_LEN] pattern to load, bit 0 shifted into the chain first
//   pat_valid             pat_data is valid
//   pat_ready             controller takes a pattern on this edge
//   rsp_data  [CHAIN_LEN] unloaded chain contents
//   rsp_valid             rsp_data is valid
//   rsp_ready             consumer takes rsp_data on this edge
// master: pattern source / response sink.  slave: the controller.
// CHAIN_LEN must match the CHAIN_LEN of the attached controller.
// ---------------------------------------------------------------------------
interface scan_shift_ctrl_if #(
  parameter int CHAIN_LEN = 8
);
  logic [CHAIN_LEN-1:0] pat_data;
  logic                 pat_valid;
  logic                 pat_ready;
  logic [CHAIN_LEN-1:0] rsp_data;
  logic                 rsp_valid;
  logic                 rsp_ready;

  modport master (
    output pat_data, pat_valid, rsp_ready,
    input  pat_ready, rsp_data, rsp_valid
  );

  modport slave (
    input  pat_data, pat_valid, rsp_ready,
    output pat_ready, rsp_data, rsp_valid
  );
endinterface

// File: rtl/scan_shift_ctrl.sv
// ---------------------------------------------------------------------------
// scan_shift_ctrl
// Drives one scan chain through load/unload (SHIFT), functional capture
// (CAPTURE) and hands the unloaded contents out (RESP).
//   CK        clock, all state on rising edge
//   RN        asynchronous active-low reset
//   bus       handshake bundle (slave side): pattern in, response out
//   abort     synchronous abort, returns to IDLE with highest priority
//   SE        scan enable to every chain flop (registered)
//   SI        serial data to the first chain flop (registered)
//   SO        Q of the last chain flop
//   busy      high whenever the controller is not in IDLE (registered)
// Timing: acceptance edge t0, shift edges t0+1..t0+CHAIN_LEN, capture edges
// t0+CHAIN_LEN+1..t0+CHAIN_LEN+CAP_CYCLES, rsp_valid high after the last.
// ---------------------------------------------------------------------------
module scan_shift_ctrl #(
  parameter int CHAIN_LEN  = 8,
  parameter int CAP_CYCLES = 1
) (
  input  logic                 CK,
  input  logic                 RN,
  scan_shift_ctrl_if.slave     bus,
  input  logic                 abort,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int CAP_W = $clog2(CAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CAP_W-1:0] LAST_CAP   = CAP_W'(CAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t               state;
  logic [CHAIN_LEN-1:0] pat_sr;
  logic [CHAIN_LEN-1:0] rsp_sr;
  logic [CNT_W-1:0]     cnt;
  logic [CAP_W-1:0]     cap_cnt;
  logic                 se_q;
  logic                 si_q;
  logic                 pat_ready_q;
  logic                 rsp_valid_q;
  logic                 busy_q;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state       <= IDLE;
      pat_sr      <= '0;
      rsp_sr      <= '0;
      cnt         <= '0;
      cap_cnt     <= '0;
      se_q        <= 1'b0;
      si_q        <= 1'b0;
      pat_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (abort) begin
      // Abort wins over every transition, including acceptance in IDLE.
      // rsp_sr is left alone so the last response stays readable.
      state       <= IDLE;
      cnt         <= '0;
      cap_cnt     <= '0;
      se_q        <= 1'b0;
      si_q        <= 1'b0;
      pat_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pat_valid) begin
            state       <= SHIFT;
            pat_sr      <= bus.pat_data;
            cnt         <= '0;
            se_q        <= 1'b1;
            si_q        <= bus.pat_data[0];
            pat_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end

        SHIFT: begin
          // SO seen before shift edge k lands in rsp bit k once all
          // CHAIN_LEN bits have entered from the top.
          rsp_sr <= {SO, rsp_sr[CHAIN_LEN-1:1]};
          pat_sr <= pat_sr >> 1;
          si_q   <= pat_sr[1];
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_SHIFT) begin
            // cnt stops at CHAIN_LEN, which still fits, so it never wraps.
            state   <= CAPTURE;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            cap_cnt <= '0;
          end
        end

        CAPTURE: begin
          cap_cnt <= cap_cnt + CAP_W'(1);
          if (cap_cnt == LAST_CAP) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            pat_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          se_q        <= 1'b0;
          si_q        <= 1'b0;
          pat_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign SE            = se_q;
  assign SI            = si_q;
  assign busy          = busy_q;
  assign bus.pat_ready = pat_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_sr;

endmodule

// File: tb/tb_scan_shift_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scan_shift_ctrl
// Directed bench for scan_shift_ctrl with CHAIN_LEN=4, CAP_CYCLES=1 driving a
// 4-flop chain whose functional D pins are tied to 4'b1010, preloaded 4'b0000.
// The chain's functional clock is modelled as gated: it only captures during
// the controller's capture window (busy, SE low, no response pending).
// ---------------------------------------------------------------------------
module tb_scan_shift_ctrl;

  localparam int CL = 4;

  logic CK;
  logic RN;
  logic abort;
  logic SE;
  logic SI;
  logic SO;
  logic busy;

  logic [CL-1:0] chain;

  int n_checks;
  int n_errors;

  scan_shift_ctrl_if #(.CHAIN_LEN(CL)) bus ();

  scan_shift_ctrl #(
    .CHAIN_LEN  (CL),
    .CAP_CYCLES (1)
  ) dut (
    .CK    (CK),
    .RN    (RN),
    .bus   (bus),
    .abort (abort),
    .SE    (SE),
    .SI    (SI),
    .SO    (SO),
    .busy  (busy)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  // Scan chain: chain[0] is fed by SI, chain[3] drives SO.
  initial chain = 4'b0000;
  always @(posedge CK) begin
    if (SE)
      chain <= {chain[CL-2:0], SI};
    else if (busy && !bus.rsp_valid)
      chain <= 4'b1010;
  end
  assign SO = chain[CL-1];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Accepts pat on the next edge, checks SE/SI before each of the following
  // five edges, and checks the response after the capture edge. Leaves the
  // controller in RESP with rsp_ready low.
  task automatic run_pattern(input string name, input logic [CL-1:0] pat,
                             input logic [CL-1:0] exp_rsp);
    bus.pat_data  = pat;
    bus.pat_valid = 1'b1;
    tick();
    bus.pat_valid = 1'b0;
    check_val($sformatf("%s_busy_t0", name), busy, 1);
    check_val($sformatf("%s_pat_ready_t0", name), bus.pat_ready, 0);
    for (int k = 1; k <= CL + 1; k++) begin
      check_val($sformatf("%s_se_e%0d", name, k), SE, (k <= CL) ? 1 : 0);
      check_val($sformatf("%s_si_e%0d", name, k), SI, (k <= CL) ? pat[k-1] : 1'b0);
      check_val($sformatf("%s_rsp_valid_e%0d", name, k), bus.rsp_valid, 0);
      tick();
    end
    check_val($sformatf("%s_rsp_valid", name), bus.rsp_valid, 1);
    check_val($sformatf("%s_rsp_data", name), bus.rsp_data, exp_rsp);
    check_val($sformatf("%s_se_resp", name), SE, 0);
    check_val($sformatf("%s_busy_resp", name), busy, 1);
  endtask

  task automatic handshake(input string name);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_val($sformatf("%s_idle_rsp_valid", name), bus.rsp_valid, 0);
    check_val($sformatf("%s_idle_pat_ready", name), bus.pat_ready, 1);
    check_val($sformatf("%s_idle_busy", name), busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int hs;
    int min_gap;
    int low_run;
    bit seen_high;
    bit prev_se;

    n_checks      = 0;
    n_errors      = 0;
    RN            = 1'b1;
    abort         = 1'b0;
    bus.pat_data  = '0;
    bus.pat_valid = 1'b0;
    bus.rsp_ready = 1'b0;

    // Reset applied between edges, observed before any clock edge.
    #1 RN = 1'b0;
    #2;
    check_val("rst_se", SE, 0);
    check_val("rst_si", SI, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_rsp_valid", bus.rsp_valid, 0);
    check_val("rst_rsp_data", bus.rsp_data, 0);
    check_val("rst_pat_ready", bus.pat_ready, 1);
    #4 RN = 1'b1;

    // Scenario 1: first edge after release accepts; chain held 0000.
    run_pattern("s1", 4'b0011, 4'b0000);
    handshake("s1");

    // Scenario 2: chain now holds captured 1010, unloaded last flop first.
    run_pattern("s2", 4'b1111, 4'b0101);

    // Scenario 3: response held while rsp_ready stays low.
    for (int c = 0; c < 10; c++) begin
      tick();
      check_val("s3_rsp_valid", bus.rsp_valid, 1);
      check_val("s3_rsp_data", bus.rsp_data, 4'b0101);
      check_val("s3_se", SE, 0);
      check_val("s3_pat_ready", bus.pat_ready, 0);
    end
    handshake("s3");
    check_val("s3_rsp_data_kept", bus.rsp_data, 4'b0101);

    // Scenario 4: abort sampled on shift edge t0+2.
    bus.pat_data  = 4'b0110;
    bus.pat_valid = 1'b1;
    tick();
    bus.pat_valid = 1'b0;
    tick();
    check_val("s4_se_before_abort", SE, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("s4_se", SE, 0);
    check_val("s4_si", SI, 0);
    check_val("s4_busy", busy, 0);
    check_val("s4_pat_ready", bus.pat_ready, 1);
    check_val("s4_rsp_valid", bus.rsp_valid, 0);
    for (int c = 0; c < 8; c++) begin
      tick();
      check_val("s4_no_rsp_valid", bus.rsp_valid, 0);
      check_val("s4_no_se", SE, 0);
    end
    // abort together with pat_valid in IDLE must not accept.
    abort         = 1'b1;
    bus.pat_valid = 1'b1;
    tick();
    abort         = 1'b0;
    bus.pat_valid = 1'b0;
    check_val("s4_abort_pv_busy", busy, 0);
    check_val("s4_abort_pv_se", SE, 0);
    check_val("s4_abort_pv_pat_ready", bus.pat_ready, 1);

    // Scenario 5: chain is 1001 after the aborted shift; load 1100, then
    // reset during CAPTURE before the capture edge.
    bus.pat_data  = 4'b1100;
    bus.pat_valid = 1'b1;
    tick();
    bus.pat_valid = 1'b0;
    for (int k = 0; k < CL; k++) tick();
    check_val("s5_in_capture_busy", busy, 1);
    check_val("s5_in_capture_se", SE, 0);
    #2 RN = 1'b0;
    #1;
    check_val("s5_rst_se", SE, 0);
    check_val("s5_rst_si", SI, 0);
    check_val("s5_rst_busy", busy, 0);
    check_val("s5_rst_rsp_valid", bus.rsp_valid, 0);
    check_val("s5_rst_rsp_data", bus.rsp_data, 0);
    check_val("s5_rst_pat_ready", bus.pat_ready, 1);
    #1 RN = 1'b1;
    // Chain was left at 0011 (no capture happened), unloaded as 1100.
    run_pattern("s5", 4'b0101, 4'b1100);
    handshake("s5");

    // Scenario 6: pat_valid and rsp_ready held high across three sequences.
    bus.pat_data  = 4'b1001;
    bus.pat_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    acc       = 0;
    hs        = 0;
    min_gap   = 99;
    low_run   = 0;
    seen_high = 1'b0;
    prev_se   = SE;
    for (int c = 0; c < 60 && hs < 3; c++) begin
      if (bus.pat_valid && bus.pat_ready) acc++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        hs++;
        check_val("s6_rsp_data", bus.rsp_data, 4'b0101);
      end
      if (SE) begin
        if (!prev_se && seen_high && low_run < min_gap) min_gap = low_run;
        seen_high = 1'b1;
        low_run   = 0;
      end else begin
        low_run++;
      end
      prev_se = SE;
      tick();
    end
    bus.pat_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    check_val("s6_handshakes", hs, 3);
    check_val("s6_acceptances", acc, 3);
    check_val("s6_min_se_gap", min_gap, 3);
    check_val("s6_end_pat_ready", bus.pat_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scan_shift_ctrl.md
SCAN_SHIFT_CTRL -- requirements
Module: scan_shift_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 8: number of scan flops in the controlled chain, legal range 2..64.
REQ-002 Parameter CAP_CYCLES, default 1: number of functional (SE=0) capture clock edges per pattern, legal range 1..4.
REQ-003 CK  input  1  single clock; all state updates on its rising edge.
REQ-004 RN  input  1  asynchronous, active-low reset.
REQ-005 pat_data  input  CHAIN_LEN  scan pattern to load; bit 0 is shifted in first.
REQ-006 pat_valid  input  1  pat_data is valid.
REQ-007 pat_ready  output  1  controller accepts a pattern on this edge.
REQ-008 abort  input  1  synchronous abort of the current sequence.
REQ-009 SE  output  1  scan enable, driven to the SE pin of every chain flop.
REQ-010 SI  output  1  serial data, driven to the SD pin of the first chain flop.
REQ-011 SO  input  1  Q of the last chain flop.
REQ-012 rsp_data  output  CHAIN_LEN  unloaded chain contents.
REQ-013 rsp_valid  output  1  rsp_data is valid.
REQ-014 rsp_ready  input  1  consumer accepts rsp_data.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, SHIFT, CAPTURE, RESP.
REQ-017 pat_ready SHALL equal (state==IDLE); a pattern is accepted on an edge with pat_valid & pat_ready, and the FSM moves to SHIFT.
REQ-018 On acceptance, the controller SHALL load pat_data into a shift register, clear the shift counter, and register SE=1 and SI=pat_data[0].
REQ-019 In SHIFT, each edge SHALL do all of the following: shift the chain by one; capture SO into rsp shift register position k (k = shift index, 0 first); present the next pattern bit on SI; increment the counter.
REQ-020 After exactly CHAIN_LEN shift edges, SHIFT SHALL go to CAPTURE with registered SE=0 and SI=0.
REQ-021 CAPTURE SHALL last exactly CAP_CYCLES edges with SE=0, then go to RESP.
REQ-022 In RESP, rsp_valid SHALL be 1 and rsp_data SHALL be stable until rsp_ready; on rsp_valid & rsp_ready the FSM SHALL return to IDLE.
REQ-023 Latency SHALL be fixed: the acceptance edge is t0; the chain shifts on edges t0+1..t0+CHAIN_LEN; capture occurs on edges t0+CHAIN_LEN+1..t0+CHAIN_LEN+CAP_CYCLES; rsp_valid is first high after edge t0+CHAIN_LEN+CAP_CYCLES.
REQ-024 rsp_data[k] SHALL equal the SO value present in the cycle before shift edge t0+1+k.
REQ-025 SE, SI, pat_ready, rsp_valid and busy SHALL be driven directly from flops, with no combinational path from any input.
REQ-026 The shift counter SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never wrap.
REQ-027 abort=1 on any edge SHALL force IDLE, SE=0, SI=0, rsp_valid=0 and a cleared counter, taking priority over every other transition.
REQ-028 In IDLE, an edge with both abort=1 and pat_valid=1 SHALL NOT accept the pattern.
REQ-029 pat_valid SHALL be ignored outside IDLE; rsp_ready SHALL be ignored outside RESP.
REQ-030 rsp_data SHALL retain its last value after RESP until the next SHIFT overwrites it.

Reset
REQ-031 RN=0 SHALL immediately force IDLE, SE=0, SI=0, rsp_valid=0, pat_ready=1 after release, busy=0, rsp_data=0, and counter=0, independent of CK.
REQ-032 RN asserted mid-SHIFT or mid-CAPTURE SHALL abandon the sequence with no further SE pulses after release.
REQ-033 The first edge after RN deasserts SHALL be able to accept a pattern.

Verification
Bench setup: CHAIN_LEN=4, CAP_CYCLES=1, a chain of 4 scan flops whose D pins are tied to 4'b1010, chain preloaded to 4'b0000.
REQ-034 Scenario 1: pat_data=4'b0011 accepted at t0 -> SE=1 for edges t0+1..t0+4, SE=0 at t0+5, rsp_valid high after t0+5, rsp_data=4'b0000.
REQ-035 Scenario 2: second pattern 4'b1111 -> rsp_data equals the captured 4'b1010, reordered per REQ-024 (SO order, last flop first).
REQ-036 Scenario 3: rsp_ready held low for 10 cycles in RESP -> rsp_valid and rsp_data stable, SE=0, pat_ready=0 throughout.
REQ-037 Scenario 4: abort pulsed at shift edge t0+2 -> next cycle IDLE, SE=0, busy=0, pat_ready=1, no rsp_valid pulse.
REQ-038 Scenario 5: RN pulsed low between edges during CAPTURE -> outputs reach reset values asynchronously; a new pattern is accepted on the first edge after release.
REQ-039 Scenario 6: pat_valid held high continuously -> exactly one acceptance per completed sequence, with at least one IDLE cycle between SE high-phases.
